// File: rtl/acc_pkg.sv
// Shared encodings for the MMIO dot-product accelerator: address regions,
// CSR word offsets, control/status bit positions and the engine state type.
package acc_pkg;

    localparam logic [1:0] REGION_A   = 2'b01;
    localparam logic [1:0] REGION_B   = 2'b10;
    localparam logic [1:0] REGION_CSR = 2'b11;

    localparam logic [5:0] CSR_CTRL   = 6'h00;
    localparam logic [5:0] CSR_LEN    = 6'h01;
    localparam logic [5:0] CSR_STATUS = 6'h02;
    localparam logic [5:0] CSR_RESULT = 6'h03;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_CLR_DONE_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT   = 0;
    localparam int unsigned STATUS_DONE_BIT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_operand_buf.sv
// Operand buffer: one write port and two independent registered read ports,
// one serving the bus and one feeding the dot-product engine.
module acc_operand_buf #(
    parameter int unsigned D_WIDTH = 64,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned AW      = 6
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [D_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]      bus_raddr_i,
    output logic [D_WIDTH-1:0] bus_rdata_o,
    input  logic [AW-1:0]      eng_raddr_i,
    output logic [D_WIDTH-1:0] eng_rdata_o
);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [D_WIDTH-1:0] bus_rdata_q;
    logic [D_WIDTH-1:0] eng_rdata_q;

    // Contents are deliberately not reset so the array maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        bus_rdata_q <= mem_q[bus_raddr_i];
        eng_rdata_q <= mem_q[eng_raddr_i];
    end

    assign bus_rdata_o = bus_rdata_q;
    assign eng_rdata_o = eng_rdata_q;

endmodule

// File: rtl/mmio_acc_responder.sv
// Memory-mapped dot-product accelerator on the datapath data-memory bus:
// operand buffers A/B, CTRL/LEN/STATUS/RESULT CSRs and a pipelined MAC engine.
module mmio_acc_responder
    import acc_pkg::*;
#(
    parameter int unsigned D_WIDTH   = 64,
    parameter int unsigned BUF_DEPTH = 64,
    parameter int unsigned LEN_WIDTH = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         mem_addr_in,
    input  logic [D_WIDTH-1:0] mem_data_in,
    input  logic               mem_we_in,
    output logic [D_WIDTH-1:0] mem_data_out,
    output logic               acc_irq
);

    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);

    // Address decode
    logic [1:0]       region;
    logic [5:0]       word;
    logic [IDX_W-1:0] buf_idx;
    logic             unused_addr_lsbs;

    assign region           = mem_addr_in[9:8];
    assign word             = mem_addr_in[7:2];
    assign buf_idx          = mem_addr_in[2 +: IDX_W];
    assign unused_addr_lsbs = ^mem_addr_in[1:0];

    // Engine and CSR state
    acc_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [LEN_WIDTH-1:0] n_q, n_d;
    logic [D_WIDTH-1:0]   acc_q, acc_d;
    logic                 done_q, done_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [1:0]           rsel_q;
    logic [D_WIDTH-1:0]   csr_rd_q, csr_rd_d;

    logic busy;
    logic csr_wr, ctrl_wr, len_wr, start_req, clr_req, start_ok;
    logic wr_a, wr_b;
    logic [LEN_WIDTH-1:0] n_start;

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_ACC);
    assign csr_wr    = mem_we_in && (region == REGION_CSR);
    assign ctrl_wr   = csr_wr && (word == CSR_CTRL);
    assign len_wr    = csr_wr && (word == CSR_LEN);
    assign start_req = ctrl_wr && mem_data_in[CTRL_START_BIT];
    assign clr_req   = ctrl_wr && mem_data_in[CTRL_CLR_DONE_BIT];
    assign start_ok  = start_req && !busy;
    assign wr_a      = mem_we_in && (region == REGION_A) && !busy;
    assign wr_b      = mem_we_in && (region == REGION_B) && !busy;
    assign n_start   = (len_q > LEN_WIDTH'(BUF_DEPTH)) ? LEN_WIDTH'(BUF_DEPTH) : len_q;

    // Operand buffers
    logic [D_WIDTH-1:0] a_bus_rdata, b_bus_rdata;
    logic [D_WIDTH-1:0] a_eng_rdata, b_eng_rdata;
    logic [D_WIDTH-1:0] product;

    acc_operand_buf #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (BUF_DEPTH),
        .AW      (IDX_W)
    ) u_buf_a (
        .clk_i       (clk),
        .we_i        (wr_a),
        .waddr_i     (buf_idx),
        .wdata_i     (mem_data_in),
        .bus_raddr_i (buf_idx),
        .bus_rdata_o (a_bus_rdata),
        .eng_raddr_i (idx_q[IDX_W-1:0]),
        .eng_rdata_o (a_eng_rdata)
    );

    acc_operand_buf #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (BUF_DEPTH),
        .AW      (IDX_W)
    ) u_buf_b (
        .clk_i       (clk),
        .we_i        (wr_b),
        .waddr_i     (buf_idx),
        .wdata_i     (mem_data_in),
        .bus_raddr_i (buf_idx),
        .bus_rdata_o (b_bus_rdata),
        .eng_raddr_i (idx_q[IDX_W-1:0]),
        .eng_rdata_o (b_eng_rdata)
    );

    assign product = a_eng_rdata * b_eng_rdata;

    // idx_q always points one entry ahead of the product being accumulated,
    // so reaching the latched count marks the final MAC of the run.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        acc_d   = acc_q;
        done_d  = done_q;
        len_d   = len_q;

        if (len_wr) begin
            len_d = mem_data_in[LEN_WIDTH-1:0];
        end
        if (clr_req) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    acc_d  = '0;
                    idx_d  = '0;
                    n_d    = n_start;
                    if (n_start == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_FETCH: begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                acc_d = acc_q + product;
                if (idx_q == n_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            len_q   <= len_d;
        end
    end

    // CSR read value is captured here; buffer words are captured inside the buffers.
    always_comb begin
        csr_rd_d = '0;
        if (region == REGION_CSR) begin
            case (word)
                CSR_LEN:    csr_rd_d = D_WIDTH'(len_q);
                CSR_STATUS: begin
                    csr_rd_d[STATUS_BUSY_BIT] = busy;
                    csr_rd_d[STATUS_DONE_BIT] = done_q;
                end
                CSR_RESULT: csr_rd_d = acc_q;
                default:    csr_rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsel_q   <= '0;
            csr_rd_q <= '0;
        end else begin
            rsel_q   <= region;
            csr_rd_q <= csr_rd_d;
        end
    end

    always_comb begin
        case (rsel_q)
            REGION_A: mem_data_out = a_bus_rdata;
            REGION_B: mem_data_out = b_bus_rdata;
            default:  mem_data_out = csr_rd_q;
        endcase
    end

    assign acc_irq = done_q;

endmodule

// File: tb/tb_mmio_acc_responder.sv
// Self-checking bench for mmio_acc_responder: register-access vector table,
// directed multi-cycle sequences and randomized runs against a dot-product model.
module tb_mmio_acc_responder;

    logic        clk;
    logic        reset_n;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic        we;
    logic [63:0] rdata;
    logic        irq;

    int checks;
    int errors;

    logic [63:0] mA [64];
    logic [63:0] mB [64];
    int unsigned mlen;

    mmio_acc_responder #(
        .D_WIDTH   (64),
        .BUF_DEPTH (64),
        .LEN_WIDTH (7)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_addr_in  (addr),
        .mem_data_in  (wdata),
        .mem_we_in    (we),
        .mem_data_out (rdata),
        .acc_irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic        we;
        logic [63:0] wdata;
        logic        chk;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cyc();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [63:0] d);
        addr = a;
        we   = 1'b0;
        cyc();
        d = rdata;
    endtask

    // Reference model: dot product over the effective count, with fixed latency rules.
    function automatic int unsigned eff_n();
        return (mlen > 64) ? 64 : mlen;
    endfunction

    function automatic logic [63:0] model_partial(input int unsigned k);
        logic [63:0] s;
        s = '0;
        for (int unsigned i = 0; i < k; i++) s = s + mA[i] * mB[i];
        return s;
    endfunction

    function automatic int model_cycles();
        return (eff_n() == 0) ? 1 : int'(eff_n()) + 2;
    endfunction

    task automatic load(input int unsigned i, input logic [63:0] a, input logic [63:0] b);
        wr(10'(32'h100 + i * 4), a);
        mA[i] = a;
        wr(10'(32'h200 + i * 4), b);
        mB[i] = b;
    endtask

    task automatic set_len(input int unsigned v);
        wr(10'h304, 64'(v));
        mlen = v & 32'h7F;
    endtask

    task automatic wait_irq(input string name, input int c0, input int exp_c);
        int c;
        c = c0;
        while (!irq && c < 300) begin
            cyc();
            c++;
        end
        check($sformatf("%s done_latency", name), 64'(c), 64'(exp_c));
    endtask

    task automatic run(input string name, input logic [63:0] ctrl);
        logic [63:0] exp_r;
        logic [63:0] d;
        int          exp_c;
        exp_r = model_partial(eff_n());
        exp_c = model_cycles();
        addr  = 10'h300;
        wdata = ctrl;
        we    = 1'b1;
        cyc();
        we    = 1'b0;
        addr  = 10'h308;
        if (exp_c > 1) begin
            cyc();
            check($sformatf("%s busy_at_T+1", name), 64'(rdata[0]), 64'd1);
            wait_irq(name, 2, exp_c);
        end else begin
            wait_irq(name, 1, exp_c);
        end
        rd(10'h30C, d);
        check($sformatf("%s result", name), d, exp_r);
        rd(10'h308, d);
        check($sformatf("%s status_after", name), d, 64'h2);
    endtask

    vec_t        tbl[$];
    logic [63:0] d;
    logic [63:0] a0;
    logic [63:0] exp_r;

    initial begin
        checks  = 0;
        errors  = 0;
        mlen    = 0;
        reset_n = 1'b0;
        addr    = '0;
        wdata   = '0;
        we      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 64'h0);
        check("reset irq", 64'(irq), 64'h0);
        reset_n = 1'b1;

        // Register/buffer access vectors: each row is one bus cycle, checked one cycle later.
        tbl.push_back('{10'h308, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h30C, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h304, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h114, 1'b1, 64'h1234, 1'b0, 64'h0});
        tbl.push_back('{10'h114, 1'b0, 64'h0, 1'b1, 64'h1234});
        tbl.push_back('{10'h117, 1'b0, 64'h0, 1'b1, 64'h1234});
        tbl.push_back('{10'h014, 1'b1, 64'hFFFF, 1'b0, 64'h0});
        tbl.push_back('{10'h114, 1'b0, 64'h0, 1'b1, 64'h1234});
        tbl.push_back('{10'h2FC, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0});
        tbl.push_back('{10'h2FC, 1'b0, 64'h0, 1'b1, 64'hDEAD_BEEF_0000_0001});
        tbl.push_back('{10'h304, 1'b1, 64'd100, 1'b0, 64'h0});
        tbl.push_back('{10'h304, 1'b0, 64'h0, 1'b1, 64'd100});
        tbl.push_back('{10'h304, 1'b1, 64'hFFFF_FFFF_FFFF_FF83, 1'b0, 64'h0});
        tbl.push_back('{10'h304, 1'b0, 64'h0, 1'b1, 64'h3});
        tbl.push_back('{10'h000, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h310, 1'b1, 64'h5, 1'b0, 64'h0});
        tbl.push_back('{10'h310, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h3FC, 1'b0, 64'h0, 1'b1, 64'h0});
        tbl.push_back('{10'h308, 1'b0, 64'h0, 1'b1, 64'h0});
        foreach (tbl[i]) begin
            addr  = tbl[i].addr;
            we    = tbl[i].we;
            wdata = tbl[i].wdata;
            cyc();
            we = 1'b0;
            if (tbl[i].chk) check($sformatf("vec%0d", i), rdata, tbl[i].exp);
        end
        mA[5]  = 64'h1234;
        mB[63] = 64'hDEAD_BEEF_0000_0001;
        mlen   = 3;

        // Small dot product: 1*5+2*6+3*7+4*8.
        for (int unsigned i = 0; i < 4; i++) load(i, 64'(i + 1), 64'(i + 5));
        set_len(4);
        check("model dot4", model_partial(eff_n()), 64'd70);
        run("dot4", 64'h1);

        // All-ones operands: every product wraps to 1.
        for (int unsigned i = 0; i < 64; i++) load(i, '1, '1);
        set_len(64);
        run("ones64", 64'h1);
        rd(10'h30C, d);
        check("ones64 result_const", d, 64'd64);
        set_len(100);
        run("len100_clamped", 64'h1);

        // Writes while busy: A[0], START and LEN must not disturb the run.
        for (int unsigned i = 0; i < 8; i++) load(i, {$urandom, $urandom}, {$urandom, $urandom});
        set_len(8);
        exp_r = model_partial(8);
        a0    = mA[0];
        wr(10'h300, 64'h1);
        wr(10'h100, 64'd99);
        wr(10'h300, 64'h1);
        wr(10'h304, 64'h1);
        mlen = 1;
        rd(10'h30C, d);
        check("busy partial_result", d, model_partial(2));
        addr = 10'h308;
        wait_irq("busy_writes", 5, 10);
        rd(10'h30C, d);
        check("busy_writes result", d, exp_r);
        rd(10'h100, d);
        check("busy_writes A0_kept", d, a0);
        rd(10'h304, d);
        check("busy_writes len_reg", d, 64'h1);

        // clr_done together with start: start wins and a new run begins.
        set_len(6);
        run("clr_and_start", 64'h3);
        wr(10'h300, 64'h2);
        check("clr_done irq", 64'(irq), 64'h0);
        set_len(0);
        run("len0", 64'h1);

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            int unsigned len;
            int unsigned k;
            len = $urandom_range(0, 80);
            for (int unsigned i = 0; i < ((len > 64) ? 64 : len); i++) begin
                load(i, {$urandom, $urandom}, {$urandom, $urandom});
            end
            set_len(len);
            if (eff_n() > 0) begin
                k = $urandom_range(0, eff_n() - 1);
                rd(10'(32'h100 + k * 4), d);
                check($sformatf("rand%0d readA", r), d, mA[k]);
                rd(10'(32'h200 + k * 4), d);
                check($sformatf("rand%0d readB", r), d, mB[k]);
            end
            run($sformatf("rand%0d len%0d", r, len), ($urandom_range(0, 1) != 0) ? 64'h3 : 64'h1);
        end

        // Asynchronous reset in the middle of a run.
        set_len(10);
        wr(10'h300, 64'h1);
        cyc();
        cyc();
        reset_n = 1'b0;
        #1;
        check("midrun_reset irq", 64'(irq), 64'h0);
        check("midrun_reset rdata", rdata, 64'h0);
        #20;
        reset_n = 1'b1;
        mlen = 0;
        rd(10'h304, d);
        check("after_reset len", d, 64'h0);
        rd(10'h308, d);
        check("after_reset status", d, 64'h0);
        set_len(5);
        run("after_reset run", 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
